// File: rtl/i2s_adc_deserializer.sv
// i2s_adc_deserializer: I2S receive stage, one scaled/saturated signed sample per frame
// Ports: clk, reset (async active-low), sclk/lrck (clk-synchronous I2S levels), adc (serial data),
//        adcScale (left-shift gain) -> adcData (sample), adcDataValid (1-clk strobe), frameError (1-clk strobe)
module i2s_adc_deserializer #(
    parameter int DataWidth  = 12,
    parameter int SlotBits   = 24,
    parameter int ScaleWidth = 6,
    parameter int Channel    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrck,
    input  logic                  adc,
    input  logic [ScaleWidth-1:0] adcScale,
    output logic [DataWidth-1:0]  adcData,
    output logic                  adcDataValid,
    output logic                  frameError
);
    localparam int CW = $clog2(SlotBits + 1);
    localparam int SW = $clog2(SlotBits);
    localparam int PW = 2 * SlotBits - 1;
    localparam logic CH = 1'(Channel);
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SlotBits-1:0] shift_q, shift_d, cap_q, cap_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic cap_vld_q, cap_vld_d, err_q, err_d, vld_q, vld_d, sclk_q, lrck_q;
    logic sclk_rise, lrck_edge, ch_open, fits, unused_ok;
    logic [PW-1:0] p;
    assign sclk_rise = sclk & ~sclk_q;
    assign lrck_edge = lrck ^ lrck_q;
    assign ch_open   = lrck_edge && (lrck == CH);
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        cap_d     = cap_q;
        sh_d      = sh_q;
        cap_vld_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: state_d = ch_open ? DELAY : IDLE;
            DELAY, SHIFT: begin
                // an lrck change aborts the slot before any sclk rise in the same cycle
                if (lrck_edge) begin
                    err_d   = 1'b1;
                    state_d = ch_open ? DELAY : IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (sclk_rise && state_q == DELAY) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[SlotBits-2:0], adc};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(SlotBits - 1)) begin
                        cap_d     = shift_d;
                        cap_vld_d = 1'b1;
                        sh_d      = (adcScale > ScaleWidth'(SlotBits - 1)) ? SW'(SlotBits - 1) : SW'(adcScale);
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // sign-extend, shift, then saturate if the product no longer fits in SlotBits signed bits
    always_comb begin
        p      = {{(PW-SlotBits){cap_q[SlotBits-1]}}, cap_q} << sh_q;
        fits   = p[PW-1:SlotBits-1] == {SlotBits{p[PW-1]}};
        vld_d  = cap_vld_q;
        data_d = !cap_vld_q ? data_q :
                 fits       ? p[SlotBits-1 -: DataWidth] :
                 p[PW-1]    ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
    end
    assign unused_ok = ^{p[SlotBits-DataWidth-1:0], shift_q[SlotBits-1]};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            cap_q     <= '0;
            sh_q      <= '0;
            cap_vld_q <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            sclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            cap_q     <= cap_d;
            sh_q      <= sh_d;
            cap_vld_q <= cap_vld_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            sclk_q    <= sclk;
            lrck_q    <= lrck;
        end
    end
    assign adcData      = data_q;
    assign adcDataValid = vld_q;
    assign frameError   = err_q;
endmodule

// File: tb/tb_i2s_adc_deserializer.sv
// tb_i2s_adc_deserializer: directed-vector bench for i2s_adc_deserializer
module tb_i2s_adc_deserializer;
    logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, lrck = 1'b1, adc = 1'b0;
    logic [5:0] adcScale = '0;
    logic [11:0] adcData;
    logic adcDataValid, frameError;
    int cyc = 0, n_checks = 0, n_errors = 0, n_valid = 0, n_ferr = 0;
    int last_cyc = 0, prev_cyc = 0, rise_cyc = 0, v0, f0, c1, c2;
    logic [11:0] last_data = '0;

    i2s_adc_deserializer dut (
        .clk(clk), .reset(reset), .sclk(sclk), .lrck(lrck), .adc(adc), .adcScale(adcScale),
        .adcData(adcData), .adcDataValid(adcDataValid), .frameError(frameError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (adcDataValid) begin
            n_valid++;
            last_data = adcData;
            prev_cyc = last_cyc;
            last_cyc = cyc;
        end
        if (frameError) n_ferr++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one sclk period (4 clk); called at a negedge, returns at a negedge
    task automatic bitc(input logic lr, input logic d, input logic mark);
        sclk = 1'b0;
        lrck = lr;
        adc = d;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        if (mark) rise_cyc = cyc;
        repeat (2) @(negedge clk);
    endtask

    // k=0 is the I2S delay bit, k=1..24 carry the slot MSB first
    task automatic half(input logic lr, input logic [23:0] w, input int n, input logic mk);
        for (int k = 0; k < n; k++) bitc(lr, (k >= 1 && k <= 24) ? w[24-k] : 1'b0, mk && k == 24);
    endtask

    task automatic run(input logic [23:0] l, input logic [23:0] r, input logic [5:0] sc, input int exp, input string tag);
        adcScale = sc;
        v0 = n_valid;
        half(1'b0, l, 32, 1'b1);
        half(1'b1, r, 32, 1'b0);
        check({tag, " count"}, n_valid - v0, 1);
        check({tag, " data"}, int'(last_data), exp);
        check({tag, " latency"}, last_cyc - rise_cyc, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset data", int'(adcData), 0);
        check("reset valid", int'(adcDataValid), 0);
        check("reset ferr", int'(frameError), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run(24'h123456, 24'hFFFFFF, 6'd0, 12'h123, "t1 left");
        run(24'h012345, 24'h000000, 6'd4, 12'h123, "t2 shift4");
        run(24'h012345, 24'h000000, 6'd40, 12'h7FF, "t2 clamp pos");
        run(24'h800000, 24'h000000, 6'd40, 12'h800, "t2 clamp neg");
        run(24'h400000, 24'h000000, 6'd1, 12'h7FF, "t3 sat pos");
        run(24'hBFFFFF, 24'h000000, 6'd1, 12'h800, "t3 sat neg");
        run(24'hFFF000, 24'h000000, 6'd0, 12'hFFF, "neg noshift");
        v0 = n_valid;
        f0 = n_ferr;
        half(1'b0, 24'hABCDEF, 11, 1'b0);
        half(1'b1, 24'h000000, 32, 1'b0);
        check("t4 ferr", n_ferr - f0, 1);
        check("t4 no valid", n_valid - v0, 0);
        run(24'h123456, 24'h000000, 6'd0, 12'h123, "t4 recover");
        v0 = n_valid;
        f0 = n_ferr;
        for (int k = 0; k < 32; k++) begin
            bitc(1'b0, (k >= 1 && k <= 24) ? k[0] : 1'b0, 1'b0);
            if (k == 12) begin
                #3 reset = 1'b0;
                #1;
                check("t5 rst data", int'(adcData), 0);
                check("t5 rst valid", int'(adcDataValid), 0);
                check("t5 rst ferr", int'(frameError), 0);
                @(negedge clk);
                reset = 1'b1;
            end
        end
        half(1'b1, 24'h000000, 32, 1'b0);
        check("t5 no valid", n_valid - v0, 0);
        check("t5 no ferr", n_ferr - f0, 0);
        run(24'h654321, 24'h000000, 6'd0, 12'h654, "t5 after");
        run(24'h7FFFFF, 24'h000000, 6'd0, 12'h7FF, "t6 max");
        c1 = last_cyc;
        run(24'h800000, 24'h000000, 6'd0, 12'h800, "t6 min");
        c2 = last_cyc;
        check("t6 spacing1", c2 - c1, 256);
        run(24'h000000, 24'h000000, 6'd0, 12'h000, "t6 zero");
        check("t6 spacing2", last_cyc - prev_cyc, 256);
        run(24'h123456, 24'h000000, 6'd0, 12'h123, "t6 nonzero");
        v0 = n_valid;
        f0 = n_ferr;
        repeat (200) @(negedge clk);
        check("static valid", n_valid - v0, 0);
        check("static ferr", n_ferr - f0, 0);
        check("static hold", int'(adcData), 12'h123);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
